// File: rtl/uart_pkg.sv
// Shared types and default parameters for the UART echo path.
package uart_pkg;

    localparam int DEF_CLK_PER_HALF_BIT = 5208;
    localparam int DEF_FIFO_DEPTH       = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LAUNCH,
        TX_GUARD,
        TX_WAIT
    } tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 8N1, mid-bit sampling after a 2-flop synchroniser.
// A start needs a high-to-low transition, so a low stop bit cannot re-trigger.
module uart_rx #(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    output logic [7:0] rdata,
    output logic       rx_ready,
    output logic       ferr,
    input  logic       rxd,
    input  logic       clk,
    input  logic       rstn
);

    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int CW       = $clog2(BIT_CLKS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     st;
    logic          rxd_m, rxd_s, rxd_p;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;

    // Synchronise the serial line and keep one cycle of history for edge detection.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_p <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
            rxd_p <= rxd_s;
        end
    end

    // Receive FSM: confirm start at half bit, then sample data and stop at bit centres.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            st       <= RX_IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '0;
            rdata    <= '0;
            rx_ready <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            rx_ready <= 1'b0;
            case (st)
                RX_IDLE: if (rxd_p && !rxd_s) begin
                    cnt <= CW'(CLK_PER_HALF_BIT - 1);
                    st  <= RX_START;
                end
                RX_START: if (cnt != '0) cnt <= cnt - 1'b1;
                    else if (!rxd_s) begin
                        cnt <= CW'(BIT_CLKS - 1);
                        idx <= 3'd0;
                        st  <= RX_DATA;
                    end else st <= RX_IDLE;
                RX_DATA: if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        sh  <= {rxd_s, sh[7:1]};
                        cnt <= CW'(BIT_CLKS - 1);
                        idx <= idx + 1'b1;
                        if (idx == 3'd7) st <= RX_STOP;
                    end
                RX_STOP: if (cnt != '0) cnt <= cnt - 1'b1;
                    else begin
                        rdata    <= sh;
                        ferr     <= !rxd_s;
                        rx_ready <= 1'b1;
                        st       <= RX_IDLE;
                    end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head is readable combinationally.
// A push while full is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic             do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign level   = wptr - rptr;
    assign rdata   = mem[rptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array; no reset needed since reads are gated by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    // Pointer update.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1, LSB first, bit time = 2*CLK_PER_HALF_BIT clocks.
// tx_busy covers the whole frame including the full stop bit.
module uart_tx #(
    parameter int CLK_PER_HALF_BIT = 5208
) (
    input  logic [7:0] data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       txd,
    input  logic       clk,
    input  logic       rstn
);

    localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
    localparam int CW       = $clog2(BIT_CLKS);

    logic [9:0]    shreg;
    logic [CW-1:0] cnt;
    logic [3:0]    nbits;

    // Frame shifter: load on start, shift one bit per bit time, drop busy after stop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shreg   <= '1;
            cnt     <= '0;
            nbits   <= '0;
            tx_busy <= 1'b0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                shreg   <= {1'b1, data, 1'b0};
                cnt     <= CW'(BIT_CLKS - 1);
                nbits   <= 4'd9;
                tx_busy <= 1'b1;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else if (nbits == 4'd0) begin
            tx_busy <= 1'b0;
        end else begin
            shreg <= {1'b1, shreg[9:1]};
            cnt   <= CW'(BIT_CLKS - 1);
            nbits <= nbits - 1'b1;
        end
    end

    assign txd = shreg[0];

endmodule

// File: rtl/uart_echo_fifo.sv
// Buffered UART echo: received bytes queue in a FIFO and drain back out of uart_tx.
// Optional build macro UART_ECHO_FERR_DROP_EN: when defined, bytes with a framing
// error are counted but not queued.
//
// state     | meaning
// TX_IDLE   | waiting for data, pause low and transmitter free; pops on launch
// TX_LAUNCH | tx_start high for this single cycle
// TX_GUARD  | transmitter latching the start; tx_busy not yet trustworthy
// TX_WAIT   | frame in flight; leave when tx_busy drops
module uart_echo_fifo
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = DEF_CLK_PER_HALF_BIT,
    parameter int FIFO_DEPTH       = DEF_FIFO_DEPTH,
    parameter int CNT_W            = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        rxd,
    output logic                        txd,
    input  logic                        pause,
    input  logic                        clr_status,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        ovf_flag,
    output logic [CNT_W-1:0]            ovf_cnt,
    output logic [CNT_W-1:0]            ferr_cnt,
    output logic                        busy
);

    logic [7:0] rx_data, fifo_rdata, tx_data;
    logic       rx_ready, rx_ferr, push_req, ovf_evt, pop;
    logic       fifo_full, fifo_empty;
    logic       tx_start, tx_start_d, tx_busy;
    tx_state_t  state_q, state_d;

    uart_rx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_rx (
        .rdata(rx_data), .rx_ready(rx_ready), .ferr(rx_ferr),
        .rxd(rxd), .clk(clk), .rstn(rstn)
    );

    uart_tx #(.CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)) u_tx (
        .data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .txd(txd), .clk(clk), .rstn(rstn)
    );

`ifdef UART_ECHO_FERR_DROP_EN
    assign push_req = rx_ready && !rx_ferr;
`else
    assign push_req = rx_ready;
`endif

    // Full with a same-cycle pop frees a slot, so that case is not a drop.
    assign ovf_evt = push_req && fifo_full && !pop;
    assign busy    = !fifo_empty || (state_q != TX_IDLE);

    uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rstn(rstn), .push(push_req), .pop(pop),
        .wdata(rx_data), .rdata(fifo_rdata),
        .full(fifo_full), .empty(fifo_empty), .level(level)
    );

    // TX FSM registers: state, one-cycle start strobe, and the popped byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= TX_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            state_q  <= state_d;
            tx_start <= tx_start_d;
            if (pop) tx_data <= fifo_rdata;
        end
    end

    // TX FSM next state and pop decision.
    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        pop        = 1'b0;
        case (state_q)
            TX_IDLE: if (!fifo_empty && !pause && !tx_busy) begin
                pop        = 1'b1;
                tx_start_d = 1'b1;
                state_d    = TX_LAUNCH;
            end
            TX_LAUNCH: state_d = TX_GUARD;
            TX_GUARD:  state_d = TX_WAIT;
            TX_WAIT:   if (!tx_busy) state_d = TX_IDLE;
            default:   state_d = TX_IDLE;
        endcase
    end

    // Status: sticky overflow flag and saturating counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rstn || clr_status) begin
            ovf_flag <= 1'b0;
            ovf_cnt  <= '0;
            ferr_cnt <= '0;
        end else begin
            if (ovf_evt) begin
                ovf_flag <= 1'b1;
                if (ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
            end
            if (rx_ready && rx_ferr && ferr_cnt != '1) ferr_cnt <= ferr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Scoreboarded bench for uart_echo_fifo: directed serial frames in, echoes decoded
// from txd by an independent monitor and compared against an expected-byte queue.
module tb_uart_echo_fifo;
    import uart_pkg::*;

    localparam int HALF  = 4;
    localparam int DEPTH = 4;
    localparam int BIT   = 2 * HALF;

    logic       clk = 1'b0;
    logic       rstn, rxd, pause, clr_status;
    logic       txd, ovf_flag, busy;
    logic [2:0] level;
    logic [7:0] ovf_cnt, ferr_cnt;

    logic [7:0] exp_q[$];
    int         tests = 0;
    int         fails = 0;
    bit         ignore = 1'b0;
    bit         mon_busy = 1'b0;
    int         mon_starts = 0;
    int         tx_start_cnt = 0;

    uart_echo_fifo #(.CLK_PER_HALF_BIT(HALF), .FIFO_DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .rxd(rxd), .txd(txd), .pause(pause),
        .clr_status(clr_status), .level(level), .ovf_flag(ovf_flag),
        .ovf_cnt(ovf_cnt), .ferr_cnt(ferr_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dut.tx_start === 1'b1) tx_start_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (BIT) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(posedge clk);
            #1;
        end
        rxd = stop;
        repeat (BIT) @(posedge clk);
        #1;
        rxd = 1'b1;
        repeat (BIT) @(posedge clk);
        #1;
    endtask

    task automatic wait_rx_ready(input string name);
        int n = 0;
        while (n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (dut.rx_ready === 1'b1) break;
        end
        check(name, 32'(n < 400), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || mon_busy) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(n < 3000), 32'd1);
    endtask

    // Monitor: decode txd frames and compare with the scoreboard queue.
    initial begin : monitor
        logic       prev;
        logic [8:0] fr;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && !txd) begin
                mon_busy = 1'b1;
                mon_starts++;
                repeat (BIT + BIT / 2) @(negedge clk);
                for (int i = 0; i < 9; i++) begin
                    fr[i] = txd;
                    if (i < 8) repeat (BIT) @(negedge clk);
                end
                if (!ignore) begin
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL echo_unexpected: got %0h expected none", fr);
                    end else begin
                        e = exp_q.pop_front();
                        if (fr !== {1'b1, e}) begin
                            fails++;
                            $display("FAIL echo_byte: got %0h expected %0h", fr, {1'b1, e});
                        end
                    end
                end
                mon_busy = 1'b0;
            end
            prev = txd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t0;
        rstn = 1'b0; rxd = 1'b1; pause = 1'b0; clr_status = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf_flag", 32'(ovf_flag), 0);
        check("rst_ovf_cnt", 32'(ovf_cnt), 0);
        check("rst_ferr_cnt", 32'(ferr_cnt), 0);
        check("rst_txd", 32'(txd), 1);
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Single byte with latency check.
        exp_q.push_back(8'h55);
        fork send_byte(8'h55, 1'b1); join_none
        wait_rx_ready("single_rx_ready");
        @(posedge clk); #1;
        check("lat_n1_level", 32'(level), 1);
        check("lat_n1_tx_start", 32'(dut.tx_start), 0);
        @(posedge clk); #1;
        check("lat_n2_tx_start", 32'(dut.tx_start), 1);
        wait_idle("single_drain");
        check("single_level", 32'(level), 0);
        check("single_busy", 32'(busy), 0);

        // Paused burst of four fills the FIFO exactly.
        pause = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        check("burst_level", 32'(level), 4);
        check("burst_ovf_flag", 32'(ovf_flag), 0);
        t0 = tx_start_cnt;
        pause = 1'b0;
        wait_idle("burst_drain");
        check("burst_tx_starts", 32'(tx_start_cnt - t0), 4);

        // Full FIFO: push coincides with pop, so no overflow.
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'h21 + 8'(i));
            send_byte(8'h21 + 8'(i), 1'b1);
        end
        check("sim_full_level", 32'(level), 4);
        exp_q.push_back(8'h25);
        fork send_byte(8'h25, 1'b1); join_none
        wait_rx_ready("sim_rx_ready");
        pause = 1'b0;
        @(posedge clk); #1;
        check("sim_level", 32'(level), 4);
        check("sim_popped", 32'(dut.state_q), 32'(TX_LAUNCH));
        check("sim_ovf_cnt", 32'(ovf_cnt), 0);
        check("sim_ovf_flag", 32'(ovf_flag), 0);
        wait_idle("sim_drain");

        // Framing error with stop bit low.
`ifndef UART_ECHO_FERR_DROP_EN
        exp_q.push_back(8'hA5);
`endif
        send_byte(8'hA5, 1'b0);
        check("ferr_cnt_one", 32'(ferr_cnt), 1);
`ifdef UART_ECHO_FERR_DROP_EN
        check("ferr_drop_level", 32'(level), 0);
`endif
        wait_idle("ferr_drain");
`ifndef UART_ECHO_FERR_DROP_EN
        exp_q.push_back(8'h3C);
`endif
        fork send_byte(8'h3C, 1'b0); join_none
        wait_rx_ready("ferr_clr_rx_ready");
        clr_status = 1'b1;
        @(posedge clk); #1;
        clr_status = 1'b0;
        check("ferr_clr_priority", 32'(ferr_cnt), 0);
        wait_idle("ferr_clr_drain");

        // Overflow: six bytes into a four-deep FIFO.
        pause = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) exp_q.push_back(8'h10 + 8'(i));
            send_byte(8'h10 + 8'(i), 1'b1);
        end
        check("ovf_level", 32'(level), 4);
        check("ovf_flag", 32'(ovf_flag), 1);
        check("ovf_cnt", 32'(ovf_cnt), 2);
        pause = 1'b0;
        wait_idle("ovf_drain");

        // Reset during a transmission with queued bytes.
        pause = 1'b1;
        for (int i = 0; i < 3; i++) send_byte(8'h31 + 8'(i), 1'b1);
        check("mid_rst_level3", 32'(level), 3);
        ignore = 1'b1;
        pause = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check("mid_rst_level2", 32'(level), 2);
        rstn = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_level", 32'(level), 0);
        check("mid_rst_state", 32'(dut.state_q), 32'(TX_IDLE));
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ovf_cnt", 32'(ovf_cnt), 0);
        check("mid_rst_ovf_flag", 32'(ovf_flag), 0);
        check("mid_rst_txd", 32'(txd), 1);
        rstn = 1'b1;
        t0 = mon_starts;
        begin
            int s0;
            s0 = tx_start_cnt;
            repeat (300) @(posedge clk);
            #1;
            check("post_rst_no_start", 32'(tx_start_cnt - s0), 0);
        end
        check("post_rst_no_frame", 32'(mon_starts - t0), 0);
        check("post_rst_level", 32'(level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Buffered UART echo block that generalises the single-byte loopback.
- Received bytes (from uart_rx) are queued in a parametrised synchronous FIFO.
- Queued bytes drain through uart_tx back-to-back, so bursts are echoed without loss up to FIFO_DEPTH bytes.
- Adds a pause control, FIFO level and overflow / framing-error status, and counters for board bring-up and host-link debug.

Parameters:
- CLK_PER_HALF_BIT, 5208, clocks per half UART bit; passed unchanged to uart_tx and uart_rx.
- FIFO_DEPTH, 16, FIFO entries; must be a power of two and >= 2.
- CNT_W, 8, width of the overflow and framing-error counters; counters saturate.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; synchronous, active-low; clock clk.
- rxd  in  1  serial input, to uart_rx.
- txd  out  1  serial output, from uart_tx.
- pause  in  1  while 1, no new transmission is launched; RX keeps filling the FIFO.
- clr_status  in  1  one-cycle pulse; clears ovf_flag, ovf_cnt and ferr_cnt.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- ovf_flag  out  1  sticky; set when a byte is dropped because the FIFO is full.
- ovf_cnt  out  CNT_W  number of dropped bytes, saturating.
- ferr_cnt  out  CNT_W  number of framing errors seen, saturating.
- busy  out  1  1 when the FIFO is non-empty or the TX FSM is not in TX_IDLE.

Behaviour:
- Reset (rstn=0 at a clk edge) values:
  - FIFO pointers and level = 0; FSM = TX_IDLE; tx_start = 0; tx data register = 0.
  - ovf_flag = 0, ovf_cnt = 0, ferr_cnt = 0, busy = 0.
  - txd follows uart_tx's reset (idle high).
  - Reset mid-frame aborts the frame and discards all queued bytes.
- Sub-block port order:
  - uart_tx (data[7:0], tx_start, tx_busy, txd, clk, rstn).
  - uart_rx (rdata[7:0], rx_ready, ferr, rxd, clk, rstn).
  - ferr is qualified by rx_ready.
- Push:
  - On the cycle rx_ready=1, rdata is written at that clock edge.
  - If the FIFO is full and no pop occurs in the same cycle: byte dropped, ovf_flag<=1, ovf_cnt increments (saturating at 2^CNT_W-1).
- Pop:
  - Issued only by the FSM in TX_IDLE.
  - Head is read combinationally and registered into the tx data register on the pop edge.
- Simultaneous push and pop:
  - Both take effect; level unchanged.
  - When full, this is NOT an overflow.
  - When empty, there is no bypass: the byte is pushed, and the pop request is not issued because empty is already seen.
- TX FSM states TX_IDLE, TX_LAUNCH, TX_GUARD, TX_WAIT:
  - TX_IDLE: if level!=0 and pause=0 and tx_busy=0, then pop, tx_start<=1, go TX_LAUNCH.
  - TX_LAUNCH: tx_start<=0, go TX_GUARD.
  - TX_GUARD: one cycle; tx_busy is ignored; go TX_WAIT.
  - TX_WAIT: when tx_busy=0, go TX_IDLE.
- tx_start is exactly one cycle wide per byte.
- Latency: rx_ready at cycle N with FIFO empty and FSM idle -> level=1 in N+1 -> tx_start=1 in N+2.
- Back-to-back bytes: the next tx_start occurs at most 2 cycles after tx_busy falls.
- pause:
  - Asserting it mid-frame does not abort; the current byte completes.
  - It only blocks the TX_IDLE launch.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH)+1 bits. Full = MSBs differ and lower bits equal; empty = pointers equal.
- ferr_cnt increments (saturating) on each rx_ready with ferr=1.
- clr_status:
  - Has priority over a same-cycle increment: the counter becomes 0, not 1.
  - Same-cycle overflow: ovf_flag stays 0.

Optional Feature:
Macro UART_ECHO_FERR_DROP_EN.
- Defined: a byte received with ferr=1 is not pushed (still counted in ferr_cnt), and does not count as an overflow.
- Undefined: bytes with ferr=1 are pushed and echoed like any other byte; ferr_cnt still counts.

Decomposition:
- Package uart_pkg holds:
  - the TX FSM state enum (tx_state_t: TX_IDLE, TX_LAUNCH, TX_GUARD, TX_WAIT);
  - localparam defaults DEF_CLK_PER_HALF_BIT=5208 and DEF_FIFO_DEPTH=16.
- One natural sub-module: uart_sync_fifo #(WIDTH, DEPTH).
  - Ports: push, pop, wdata, rdata, full, empty, level.
  - Reusable for later UART command paths.
- uart_tx and uart_rx are instantiated unchanged.

Test Plan:
- CLK_PER_HALF_BIT=4, FIFO_DEPTH=4; send 0x55 on rxd -> txd echoes 0x55; tx_start exactly 2 cycles after rx_ready; level returns to 0; busy falls.
- Burst of 4 bytes 0x01..0x04 with pause=1, then release pause -> level=4, no overflow; echo order 0x01,0x02,0x03,0x04; tx_start pulses exactly 4.
- With pause=1, send 6 bytes 0x10..0x15 -> 0x14 and 0x15 dropped; ovf_flag=1; ovf_cnt=2; echo is 0x10..0x13 after release.
- FIFO full while draining, with rx_ready coinciding with the pop cycle -> byte accepted; ovf_cnt unchanged; level stays 4.
- Frame with stop bit 0 carrying 0xA5 -> ferr_cnt=1.
  - Echoed when UART_ECHO_FERR_DROP_EN is undefined.
  - Not echoed and level stays 0 when defined.
  - clr_status pulsed alongside a new error -> ferr_cnt=0.
- rstn=0 mid-transmission with level=3 -> next cycle level=0, FSM idle, busy=0, counters 0; no further echo after rstn=1.
